// File: rtl/bram_ctrl_pkg.sv
// bram_ctrl_pkg: shared definitions for the feature-map BRAM line controller.
//   - default geometry (address width, word width, words per line)
//   - beat-counter width helper and its default value
//   - controller state enum
package bram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned DATA_W_DEF     = 64;
  localparam int unsigned LINE_WORDS_DEF = 8;

  // Width of a counter that indexes the beats of one line (at least 1 bit).
  function automatic int unsigned beat_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int unsigned BEAT_W_DEF = beat_width(LINE_WORDS_DEF);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    LAST,
    RESP
  } state_t;

endpackage

// File: rtl/bram_line_gather.sv
// bram_line_gather: beat-indexed capture register that assembles one read line.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        zero the whole line (start of a new line)
//   load         capture word into beat slot idx (takes priority over clear)
//   idx          beat index, beat k lands in data[k*DATA_W +: DATA_W]
//   word         BRAM read data for the beat being captured
//   data         assembled line
module bram_line_gather
  import bram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned BEAT_W     = BEAT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         load,
  input  logic [BEAT_W-1:0]            idx,
  input  logic [DATA_W-1:0]            word,
  output logic [LINE_WORDS*DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      for (int unsigned k = 0; k < LINE_WORDS; k++) begin
        if (idx == BEAT_W'(k)) begin
          data[k*DATA_W +: DATA_W] <= word;
        end
      end
    end else if (clear) begin
      data <= '0;
    end
  end

endmodule

// File: rtl/bram_line_ctrl.sv
// bram_line_ctrl: sequencer/arbiter in front of the single-port feature-map BRAM.
// Shares the BRAM between a single-word write requester and a line read
// requester (LINE_WORDS consecutive words), gathers each line and returns it
// through a valid/ready response.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   wr_req_valid/ready, _addr, _data   write request (word address)
//   rd_req_valid/ready, _addr          line read request (byte address, [2:0] ignored)
//   rd_rsp_valid/ready, _data          line response, beat k in [k*DATA_W +: DATA_W]
//   bram_we, bram_addr, bram_wdata     BRAM command (registered)
//   bram_rdata                         BRAM read data, one cycle after address
//   perf_rd_lines, perf_wr_words,      saturating performance counters
//   perf_stall
// Build option: define BRAM_CTRL_PERF_EN to include the performance counters;
// otherwise the perf_* outputs are tied to zero.
module bram_line_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_req_valid,
  output logic                         wr_req_ready,
  input  logic [ADDR_W-1:0]            wr_req_addr,
  input  logic [DATA_W-1:0]            wr_req_data,
  input  logic                         rd_req_valid,
  output logic                         rd_req_ready,
  input  logic [ADDR_W+2:0]            rd_req_addr,
  output logic                         rd_rsp_valid,
  input  logic                         rd_rsp_ready,
  output logic [LINE_WORDS*DATA_W-1:0] rd_rsp_data,
  output logic                         bram_we,
  output logic [ADDR_W-1:0]            bram_addr,
  output logic [DATA_W-1:0]            bram_wdata,
  input  logic [DATA_W-1:0]            bram_rdata,
  output logic [31:0]                  perf_rd_lines,
  output logic [31:0]                  perf_wr_words,
  output logic [31:0]                  perf_stall
);

  localparam int unsigned       BEAT_W    = beat_width(LINE_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  state_t              state;
  logic                last_grant_rd;  // 1: most recent grant went to the reader
  logic [ADDR_W-1:0]   rd_base;
  logic [BEAT_W-1:0]   beat;           // beat whose address is on bram_addr
  logic                cap_pend;       // bram_rdata carries beat cap_idx this cycle
  logic [BEAT_W-1:0]   cap_idx;
  logic                wr_ok;
  logic                rd_ok;
  logic                rsp_fire;
  logic                wr_grant;
  logic                rd_grant;
  logic [ADDR_W-1:0]   rd_word;
  logic                unused_addr_bits;

  assign rd_word          = rd_req_addr[ADDR_W+2:3];
  assign unused_addr_bits = ^rd_req_addr[2:0];

  // Grant logic. Writes are allowed whenever no line is being fetched; a new
  // read is allowed only once the previous response is (being) consumed.
  always_comb begin
    rsp_fire = (state == RESP) && rd_rsp_ready;
    wr_ok    = (state == IDLE) || (state == WRITE) || (state == RESP);
    rd_ok    = (state == IDLE) || (state == WRITE) || rsp_fire;
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (wr_req_valid && wr_ok && rd_req_valid && rd_ok) begin
      wr_grant = last_grant_rd;
      rd_grant = !last_grant_rd;
    end else begin
      wr_grant = wr_req_valid && wr_ok;
      rd_grant = rd_req_valid && rd_ok;
    end
  end

  assign wr_req_ready = wr_grant;
  assign rd_req_ready = rd_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant_rd <= 1'b1;
      rd_base       <= '0;
      beat          <= '0;
      cap_pend      <= 1'b0;
      cap_idx       <= '0;
      rd_rsp_valid  <= 1'b0;
      bram_we       <= 1'b0;
      bram_addr     <= '0;
      bram_wdata    <= '0;
    end else begin
      bram_we  <= wr_grant;
      // Address issued this cycle is sampled by the BRAM at the next edge and
      // its data is captured one edge later.
      cap_pend <= (state == READ);
      cap_idx  <= beat;

      if (wr_grant) begin
        bram_addr     <= wr_req_addr;
        bram_wdata    <= wr_req_data;
        last_grant_rd <= 1'b0;
      end
      if (rd_grant) begin
        rd_base       <= rd_word;
        bram_addr     <= rd_word;
        beat          <= '0;
        last_grant_rd <= 1'b1;
      end

      case (state)
        IDLE, WRITE: begin
          state <= rd_grant ? READ : (wr_grant ? WRITE : IDLE);
        end
        READ: begin
          if (beat == LAST_BEAT) begin
            state <= LAST;
          end else begin
            beat      <= beat + BEAT_W'(1);
            bram_addr <= rd_base + ADDR_W'(beat) + ADDR_W'(1);
          end
        end
        LAST: begin
          state        <= RESP;
          rd_rsp_valid <= 1'b1;
        end
        RESP: begin
          // A write granted while the response is held keeps us in RESP; the
          // BRAM write still goes out next cycle via bram_we.
          if (rd_rsp_ready) begin
            rd_rsp_valid <= 1'b0;
            state        <= rd_grant ? READ : (wr_grant ? WRITE : IDLE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bram_line_gather #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS),
    .BEAT_W     (BEAT_W)
  ) u_gather (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (rd_grant),
    .load  (cap_pend),
    .idx   (cap_idx),
    .word  (bram_rdata),
    .data  (rd_rsp_data)
  );

`ifdef BRAM_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_lines <= '0;
      perf_wr_words <= '0;
      perf_stall    <= '0;
    end else begin
      if (rsp_fire && (perf_rd_lines != '1)) begin
        perf_rd_lines <= perf_rd_lines + 32'd1;
      end
      if (wr_grant && (perf_wr_words != '1)) begin
        perf_wr_words <= perf_wr_words + 32'd1;
      end
      if (rd_rsp_valid && !rd_rsp_ready && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`else
  assign perf_rd_lines = '0;
  assign perf_wr_words = '0;
  assign perf_stall    = '0;
`endif

endmodule

// File: tb/tb_bram_line_ctrl.sv
// tb_bram_line_ctrl: self-checking bench for bram_line_ctrl.
// A behavioural BRAM sits on the bram_* port; a separate reference memory is
// updated from observed write handshakes and used to predict every line.
module tb_bram_line_ctrl;

  logic         clk;
  logic         rst_n;
  logic         wr_req_valid, wr_req_ready;
  logic [15:0]  wr_req_addr;
  logic [63:0]  wr_req_data;
  logic         rd_req_valid, rd_req_ready;
  logic [18:0]  rd_req_addr;
  logic         rd_rsp_valid, rd_rsp_ready;
  logic [511:0] rd_rsp_data;
  logic         bram_we;
  logic [15:0]  bram_addr;
  logic [63:0]  bram_wdata, bram_rdata;
  logic [31:0]  perf_rd_lines, perf_wr_words, perf_stall;

  bram_line_ctrl #(
    .ADDR_W     (16),
    .DATA_W     (64),
    .LINE_WORDS (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_req_valid  (wr_req_valid),
    .wr_req_ready  (wr_req_ready),
    .wr_req_addr   (wr_req_addr),
    .wr_req_data   (wr_req_data),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_ready  (rd_rsp_ready),
    .rd_rsp_data   (rd_rsp_data),
    .bram_we       (bram_we),
    .bram_addr     (bram_addr),
    .bram_wdata    (bram_wdata),
    .bram_rdata    (bram_rdata),
    .perf_rd_lines (perf_rd_lines),
    .perf_wr_words (perf_wr_words),
    .perf_stall    (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] mem     [65536];
  logic [63:0] ref_mem [65536];
  int unsigned m_rd, m_wr, m_stall;
  int n_chk, n_pass;

  // Behavioural BRAM: read data one cycle after the address.
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_wdata;
    bram_rdata <= mem[bram_addr];
  end

  // Handshake monitor; inputs only change just after rising edges, so the
  // falling-edge view is what the DUT sees at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_rd = 0; m_wr = 0; m_stall = 0;
    end else begin
      if (wr_req_valid && wr_req_ready) begin
        ref_mem[wr_req_addr] = wr_req_data;
        m_wr++;
      end
      if (rd_rsp_valid && rd_rsp_ready) m_rd++;
      if (rd_rsp_valid && !rd_rsp_ready) m_stall++;
    end
  end

  function automatic logic [511:0] exp_line(input logic [18:0] a);
    logic [511:0] l;
    logic [15:0]  w;
    w = a[18:3];
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = ref_mem[16'(w + 16'(k))];
    return l;
  endfunction

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  task automatic fail_to(input string nm);
    n_chk++;
    $display("FAIL %s: got no event within bound, required one", nm);
  endtask

  // All tasks start and end #1 after a rising edge.
  task automatic do_write(input logic [15:0] a, input logic [63:0] d);
    int n;
    n = 0;
    wr_req_addr = a; wr_req_data = d; wr_req_valid = 1'b1;
    @(negedge clk);
    while (!wr_req_ready && n < 64) begin @(negedge clk); n++; end
    if (!wr_req_ready) begin
      fail_to("wr_req_ready");
      wr_req_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    wr_req_valid = 1'b0;
    check("wr_bram_cmd", {bram_we, bram_addr, bram_wdata}, {1'b1, a, d});
  endtask

  task automatic read_line(input logic [18:0] a, input bit hold, output logic [511:0] d,
                           output int lat, output logic [7:0][15:0] tr);
    int n;
    n = 0; lat = -1; tr = '0; d = '0;
    rd_rsp_ready = !hold;
    rd_req_addr = a; rd_req_valid = 1'b1;
    @(negedge clk);
    while (!rd_req_ready && n < 64) begin @(negedge clk); n++; end
    if (!rd_req_ready) begin
      fail_to("rd_req_ready");
      rd_req_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    tr[0] = bram_addr;
    while (!rd_rsp_valid && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat < 8) tr[lat] = bram_addr;
    end
    if (!rd_rsp_valid) fail_to("rd_rsp_valid");
    d = rd_rsp_data;
    @(posedge clk); #1;
  endtask

  task automatic release_rsp(input logic [511:0] d, input int extra);
    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      check("rsp_held", {rd_rsp_valid, rd_rsp_data}, {1'b1, d});
      @(posedge clk); #1;
    end
    rd_rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rsp_drop", rd_rsp_valid, 1'b0);
  endtask

  typedef struct {
    logic [18:0] addr;
    logic [15:0] base;
  } rd_vec_t;

  initial begin
    rd_vec_t          vecs [6];
    logic [511:0]     d, exp;
    logic [7:0][15:0] tr, etr;
    logic [31:0]      stall0;
    logic [18:0]      a;
    int               lat, n;
    bit               quiet, hold;

    vecs[0] = '{19'h00000, 16'h0000};
    vecs[1] = '{19'h00045, 16'h0008};
    vecs[2] = '{19'h00040, 16'h0008};
    vecs[3] = '{19'h7FFF0, 16'hFFFE};
    vecs[4] = '{19'h7FFFF, 16'hFFFF};
    vecs[5] = '{19'h12343, 16'h2468};

    n_chk = 0; n_pass = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = {$urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    rst_n = 1'b0;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {wr_req_ready, rd_req_ready}, 2'b00);
    check("rst_rsp", {rd_rsp_valid, rd_rsp_data}, '0);
    check("rst_bram", {bram_we, bram_addr, bram_wdata}, '0);
    check("rst_perf", {perf_rd_lines, perf_wr_words, perf_stall}, '0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests from reset: write first, then alternate
    wr_req_addr = 16'h0041; wr_req_data = 64'hA1; wr_req_valid = 1'b1;
    rd_req_addr = 19'h00208; rd_req_valid = 1'b1;
    @(negedge clk);
    check("tie_first", {wr_req_ready, rd_req_ready}, 2'b10);
    @(posedge clk); #1;
    wr_req_addr = 16'h0042; wr_req_data = 64'hA2;
    @(negedge clk);
    check("tie_second", {wr_req_ready, rd_req_ready}, 2'b01);
    @(posedge clk); #1;
    @(negedge clk);
    exp = exp_line(19'h00208);
    check("tie_wr_blocked", wr_req_ready, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("tie_rsp_e9", rd_rsp_valid, 1'b1);
    check("tie_line1", rd_rsp_data, exp);
    check("tie_third", {wr_req_ready, rd_req_ready}, 2'b10);
    @(posedge clk); #1;
    wr_req_addr = 16'h0043; wr_req_data = 64'hA3;
    @(negedge clk);
    check("tie_fourth", {wr_req_ready, rd_req_ready}, 2'b01);
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
    @(negedge clk);
    exp = exp_line(19'h00208);
    n = 0;
    while (!rd_rsp_valid && n < 40) begin @(negedge clk); n++; end
    if (!rd_rsp_valid) fail_to("tie_rsp2");
    check("tie_line2", rd_rsp_data, exp);
    check("tie_line2_a2", rd_rsp_data[64 +: 64], 64'hA2);
    @(posedge clk); #1;
    wr_req_valid = 1'b0;
    check("tie_wr3_issued", {bram_we, bram_addr, bram_wdata}, {1'b1, 16'h0043, 64'hA3});
    @(posedge clk); #1;

    // Write words 0x10..0x17 to 0..7, read them back as one line
    for (int k = 0; k < 8; k++) do_write(16'(k), 64'h10 + 64'(k));
    read_line(19'h0, 1'b0, d, lat, tr);
    for (int k = 0; k < 8; k++) exp[k*64 +: 64] = 64'h10 + 64'(k);
    check("wr_rd_line", d, exp);
    check("wr_rd_latency", 32'(lat), 32'd9);

    // Address decode / wrap table
    foreach (vecs[i]) begin
      read_line(vecs[i].addr, 1'b0, d, lat, tr);
      for (int k = 0; k < 8; k++) etr[k] = 16'(vecs[i].base + 16'(k));
      check($sformatf("vec%0d_addrs", i), tr, etr);
      check($sformatf("vec%0d_line", i), d, exp_line({vecs[i].base, 3'b000}));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd9);
    end

    // Backpressure: 5 stall cycles, writes accepted while the line is held
    stall0 = perf_stall;
    read_line(19'h00080, 1'b1, d, lat, tr);
    exp = exp_line(19'h00080);
    check("bp_line", d, exp);
    do_write(16'h0011, 64'hDEAD_BEEF_0000_0011);
    do_write(16'h0200, 64'hCAFE_0000_0000_0200);
    release_rsp(d, 2);
`ifdef BRAM_CTRL_PERF_EN
    check("bp_perf_stall", perf_stall - stall0, 32'd5);
`else
    check("bp_perf_stall_off", perf_stall, 32'd0);
`endif
    read_line(19'h00080, 1'b0, d, lat, tr);
    check("bp_reread_word", d[64 +: 64], 64'hDEAD_BEEF_0000_0011);
    check("bp_reread_line", d, exp_line(19'h00080));

    // Reset in the middle of a line
    rd_req_addr = 19'h00800; rd_req_valid = 1'b1;
    @(negedge clk);
    check("mid_rd_ready", rd_req_ready, 1'b1);
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_beat3_addr", bram_addr, 16'h0103);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {wr_req_ready, rd_req_ready, rd_rsp_valid, bram_we, bram_addr,
                           bram_wdata, perf_rd_lines, perf_wr_words, perf_stall}, '0);
    check("mid_rst_data", rd_rsp_data, '0);
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    quiet = 1'b1;
    repeat (15) begin @(negedge clk); if (rd_rsp_valid) quiet = 1'b0; end
    check("mid_no_rsp", quiet, 1'b1);
    @(posedge clk); #1;
    read_line(19'h00800, 1'b0, d, lat, tr);
    check("mid_reread", d, exp_line(19'h00800));

    // Randomized traffic against the reference memory
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        do_write(16'($urandom_range(79, 0)), {$urandom, $urandom});
      end else begin
        a = (i % 7 == 0) ? 19'($urandom) : 19'($urandom_range(639, 0));
        hold = 1'($urandom_range(1, 0));
        read_line(a, hold, d, lat, tr);
        if (hold) release_rsp(d, int'($urandom_range(3, 0)));
        check($sformatf("rand%0d_line", i), d, exp_line(a));
        check($sformatf("rand%0d_lat", i), 32'(lat), 32'd9);
      end
    end
    rd_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

`ifdef BRAM_CTRL_PERF_EN
    check("perf_rd_lines", perf_rd_lines, 32'(m_rd));
    check("perf_wr_words", perf_wr_words, 32'(m_wr));
    check("perf_stall", perf_stall, 32'(m_stall));
`else
    check("perf_off", {perf_rd_lines, perf_wr_words, perf_stall}, '0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
